// File: rtl/vr_lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM state codes,
// the latched request record and the alignment rule.
package vr_lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t IDLE  = 2'd0;
    localparam lsu_state_t READ  = 2'd1;
    localparam lsu_state_t WRITE = 2'd2;
    localparam lsu_state_t RESP  = 2'd3;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Size code 3 is undefined and is reported as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = |lane;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/vr_lane_align.sv
// Little-endian lane handling: extracts a sub-word from a loaded word with
// sign/zero extension, and merges store data into the existing word.
module vr_lane_align
    import vr_lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [31:0] store_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves it unassigned (no latch).
        byte_shifted = load_word >> {lane, 3'b000};
        half_shifted = load_word >> {lane[1], 4'b0000};
        byte_mask    = 32'h0000_00FF << {lane, 3'b000};
        half_mask    = 32'h0000_FFFF << {lane[1], 4'b0000};
        extracted    = load_word;
        merged       = data;

        case (size)
            SIZE_BYTE: begin
                extracted = sign_ext ? {{24{byte_shifted[7]}}, byte_shifted[7:0]}
                                     : {24'h0, byte_shifted[7:0]};
                merged    = (store_word & ~byte_mask)
                          | ({24'h0, data[7:0]} << {lane, 3'b000});
            end
            SIZE_HALF: begin
                extracted = sign_ext ? {{16{half_shifted[15]}}, half_shifted[15:0]}
                                     : {16'h0, half_shifted[15:0]};
                merged    = (store_word & ~half_mask)
                          | ({16'h0, data[15:0]} << {lane[1], 4'b0000});
            end
            default: begin
                extracted = load_word;
                merged    = data;
            end
        endcase
    end

endmodule

// File: rtl/vr_load_store_unit.sv
// Load/store unit between the CPU datapath and the word-wide data memory.
// Sub-word stores read the target word first, then write back the merged word.
module vr_load_store_unit
    import vr_lsu_pkg::*;
#(
    parameter int ADDR_LIMIT = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err_misalign,
    output logic        err_range,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RW,
    output logic [31:0] MEM_WD,
    input  logic [31:0] MEM_RD
);

    lsu_state_t  state;
    lsu_req_t    req_q;
    logic [31:0] word_q;
    logic        accept;
    logic        misalign_in;
    logic        range_in;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    assign accept      = req_valid && req_ready;
    assign misalign_in = is_misaligned(req_size, req_addr[1:0]);
    assign range_in    = req_addr >= 32'(ADDR_LIMIT);

    vr_lane_align u_align (
        .load_word  (MEM_RD),
        .store_word (word_q),
        .data       (req_q.wdata),
        .size       (req_q.size),
        .lane       (req_q.addr[1:0]),
        .sign_ext   (req_q.sgn),
        .extracted  (load_value),
        .merged     (merged_word)
    );

    // Memory-side outputs depend only on registers, never on req_*.
    assign MEM_ADDR = {req_q.addr[31:2], 2'b00};
    assign MEM_WD   = (state == WRITE) ? merged_word : 32'h0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            req_q        <= '0;
            word_q       <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            MEM_RW       <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q     <= '{we: req_we, size: req_size, sgn: req_signed,
                                       addr: req_addr, wdata: req_wdata};
                        req_ready <= 1'b0;
                        if (misalign_in || range_in) begin
                            err_misalign <= misalign_in;
                            err_range    <= !misalign_in && range_in;
                            resp_valid   <= 1'b1;
                            state        <= RESP;
                        end else if (req_we && req_size == SIZE_WORD) begin
                            MEM_RW <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    word_q <= MEM_RD;
                    if (req_q.we) begin
                        MEM_RW <= 1'b1;
                        state  <= WRITE;
                    end else begin
                        resp_rdata <= load_value;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    MEM_RW     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid   <= 1'b0;
                    resp_rdata   <= '0;
                    err_misalign <= 1'b0;
                    err_range    <= 1'b0;
                    req_ready    <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    MEM_RW     <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vr_load_store_unit.sv
// Scoreboard bench for vr_load_store_unit: a byte-array reference model predicts
// each response; a negedge monitor compares whatever the unit presents.
module tb_vr_load_store_unit;
    import vr_lsu_pkg::*;

    localparam int ADDR_LIMIT = 1024;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err_misalign;
    logic        err_range;
    logic [31:0] MEM_ADDR;
    logic        MEM_RW;
    logic [31:0] MEM_WD;
    logic [31:0] MEM_RD;

    vr_load_store_unit #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .err_misalign(err_misalign), .err_range(err_range),
        .MEM_ADDR(MEM_ADDR), .MEM_RW(MEM_RW), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        rng;
        int          lat;
        int          writes;
        logic [31:0] wd;
        logic [31:0] waddr;
        int          acc;
        int          wbase;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mem [0:255];
    logic [31:0] init_words [0:255];
    logic [7:0]  ref_bytes [0:1023];
    logic        preload = 1'b1;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_mis = 1'b0;
    logic        last_rng = 1'b0;

    // Word-wide memory with combinational read and synchronous write.
    assign MEM_RD = mem[MEM_ADDR[9:2]];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_words[i];
        end else if (MEM_RW) begin
            mem[MEM_ADDR[9:2]] <= MEM_WD;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int word_idx);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_bytes[4*word_idx + i];
        return w;
    endfunction

    // Reference model: byte-addressed memory, sizes as byte counts.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        int nb;
        int a;
        logic [31:0] v;
        e = '{rdata: 32'h0, mis: 1'b0, rng: 1'b0, lat: 1, writes: 0,
              wd: 32'h0, waddr: 32'h0, acc: 0, wbase: 0};
        e.mis = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
        e.rng = !e.mis && (addr >= 32'(ADDR_LIMIT));
        if (e.mis || e.rng) return;
        nb = 1 << size;
        a  = int'(addr);
        if (!we) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
            if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            e.rdata = v;
            e.lat   = 2;
        end else begin
            for (int i = 0; i < nb; i++) ref_bytes[a + i] = 8'(wdata >> (8 * i));
            e.lat    = (nb == 4) ? 2 : 3;
            e.writes = 1;
            e.waddr  = addr & ~32'h3;
            e.wd     = ref_word(a / 4);
        end
    endtask

    // Monitor: compares memory writes and responses against the scoreboard head.
    always @(negedge CLK) begin
        if (!RST) begin
            if (MEM_RW) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(MEM_RW), 32'h0);
                end else begin
                    check("mem_addr", MEM_ADDR, sb[0].waddr);
                    check("mem_wd", MEM_WD, sb[0].wd);
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    mon_e      = sb.pop_front();
                    last_rdata = resp_rdata;
                    last_mis   = err_misalign;
                    last_rng   = err_range;
                    check("resp_rdata", resp_rdata, mon_e.rdata);
                    check("err_misalign", 32'(err_misalign), 32'(mon_e.mis));
                    check("err_range", 32'(err_range), 32'(mon_e.rng));
                    check("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                    check("write_count", 32'(wr_cnt - mon_e.wbase), 32'(mon_e.writes));
                    check("ready_in_resp", 32'(req_ready), 32'h0);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   n;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'h1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        model(we, size, sgn, addr, wdata, e);
        @(posedge CLK);
        #1;
        e.acc   = cyc;
        e.wbase = wr_cnt;
        sb.push_back(e);
        // Junk request held across the next edge while the unit is busy; it must be ignored.
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        @(negedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        int          r;

        for (int i = 0; i < 256; i++) init_words[i] = $urandom;
        init_words[0] = 32'd1;
        init_words[1] = 32'd9;
        init_words[2] = 32'd2;
        for (int i = 0; i < 1024; i++) ref_bytes[i] = init_words[i / 4][8*(i % 4) +: 8];

        repeat (2) @(negedge CLK);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_err_misalign", 32'(err_misalign), 32'h0);
        check("rst_err_range", 32'(err_range), 32'h0);
        check("rst_mem_rw", 32'(MEM_RW), 32'h0);
        check("rst_mem_addr", MEM_ADDR, 32'h0);
        check("rst_mem_wd", MEM_WD, 32'h0);
        preload = 1'b0;
        RST     = 1'b0;

        issue(1'b0, SIZE_WORD, 1'b0, 32'd4, 32'h0);
        check("t1_load_word4", last_rdata, 32'h0000_0009);
        issue(1'b1, SIZE_BYTE, 1'b0, 32'd5, 32'h0000_00AB);
        check("t2_word1", mem[1], 32'h0000_AB09);
        issue(1'b0, SIZE_BYTE, 1'b1, 32'd5, 32'h0);
        check("t3_lb_signed", last_rdata, 32'hFFFF_FFAB);
        issue(1'b0, SIZE_BYTE, 1'b0, 32'd5, 32'h0);
        check("t3_lb_unsigned", last_rdata, 32'h0000_00AB);
        issue(1'b1, SIZE_HALF, 1'b0, 32'd10, 32'h0000_1234);
        check("t3_word2", mem[2], 32'h1234_0002);
        issue(1'b0, SIZE_WORD, 1'b0, 32'd6, 32'h0);
        check("t4_misalign", 32'({last_mis, last_rng}), 32'h2);
        issue(1'b1, SIZE_WORD, 1'b0, 32'd1024, 32'hDEAD_BEEF);
        check("t5_range", 32'({last_mis, last_rng}), 32'h1);
        issue(1'b0, SIZE_WORD, 1'b0, 32'd1026, 32'h0);
        check("t5_priority", 32'({last_mis, last_rng}), 32'h2);

        // Reset during the READ cycle of a byte store to address 0.
        @(negedge CLK);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = SIZE_BYTE;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'h0000_0055;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        RST       = 1'b1;
        @(negedge CLK);
        check("t6_rw_in_reset", 32'(MEM_RW), 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        check("t6_ready", 32'(req_ready), 32'h1);
        check("t6_no_resp", 32'(resp_valid), 32'h0);
        check("t6_word0", mem[0], 32'h0000_0001);

        for (int k = 0; k < 300; k++) begin
            we   = 1'($urandom);
            size = 2'($urandom_range(0, 3));
            r    = int'($urandom_range(0, 15));
            if (r == 0)      addr = 32'(ADDR_LIMIT) + $urandom_range(0, 64);
            else if (r == 1) addr = $urandom;
            else             addr = $urandom_range(0, ADDR_LIMIT - 1);
            if (size != 2'd3 && $urandom_range(0, 9) < 7) addr = addr & ~((32'h1 << size) - 32'h1);
            issue(we, size, 1'($urandom), addr, $urandom);
        end

        repeat (3) @(negedge CLK);
        for (int w = 0; w < 256; w++) check("final_mem", mem[w], ref_word(w));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
